// File: rtl/mux_ctrl_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_ctrl_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // The mux decodes select inverted: requester i sits on select ~i.
  function automatic logic [SEL_W-1:0] idx_to_sel(input logic [SEL_W-1:0] i);
    return ~i;
  endfunction

endpackage

// File: rtl/four_bit_mux.sv
// Shared 4:1 single-bit mux; select 3..0 picks a, b, c, d.
module four_bit_mux (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic [1:0] sel,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (sel)
      2'd3:    y = a;
      2'd2:    y = b;
      2'd1:    y = c;
      default: y = d;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational round-robin picker: first set request after ptr, with wrap.
module rr_pick4
  import mux_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0]   cand [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  // cand[k] is the k-th index scanned; ptr itself is visited last.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand[gi] = ptr + SEL_W'(gi + 1);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    found = |hit;
    idx   = cand[0];
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) idx = cand[k];
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one four_bit_mux between four 1-bit requesters,
// with bursts of up to MAX_BURST accepted beats per grant.
module mux4_rr_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
  output logic               out_valid,
  output logic               out_data,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               busy
);

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   ptr_reg, ptr_next;
  logic [3:0]         count_reg, count_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               owner_req;
  logic               transfer;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  four_bit_mux u_mux (
    .a   (din[0]),
    .b   (din[1]),
    .c   (din[2]),
    .d   (din[3]),
    .sel (sel_reg),
    .y   (out_data)
  );

  // ptr always holds the current (or last) owner, so it indexes its request.
  assign owner_req = req[ptr_reg];
  assign busy      = (state_reg == GRANT);
  // A beat in flight while rst is high must not be accepted downstream.
  assign out_valid = busy && owner_req && !rst;
  assign transfer  = out_valid && out_ready;
  assign grant     = grant_reg;
  assign sel       = sel_reg;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    count_next = count_reg;
    grant_next = grant_reg;
    sel_next   = sel_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = GRANT;
          grant_next = NUM_REQ'(1) << pick_idx;
          sel_next   = idx_to_sel(pick_idx);
          ptr_next   = pick_idx;
          count_next = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_next = IDLE;
          grant_next = '0;
          count_next = '0;
        end else if (transfer) begin
          if (count_reg == LAST_BEAT) begin
            state_next = IDLE;
            grant_next = '0;
            count_next = '0;
          end else begin
            count_next = count_reg + 4'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= SEL_W'(NUM_REQ - 1);
      count_reg <= '0;
      grant_reg <= '0;
      sel_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
      grant_reg <= grant_next;
      sel_reg   <= sel_next;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: expected beats are queued as stimulus is driven.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] din;
  logic       out_valid;
  logic       out_data;
  logic       out_ready;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .busy      (busy)
  );

  typedef struct packed {
    logic [15:0] rel;
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic        data;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    cyc = 0;
  int    base = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  // Records an accepted beat in the current cycle, then advances to just after the next edge.
  task automatic tick();
    beat_t b;
    if (out_valid && out_ready) begin
      b.rel   = 16'(cyc - base);
      b.grant = grant;
      b.sel   = sel;
      b.data  = out_data;
      obs_q.push_back(b);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected beat from owner o: one-hot grant, inverted select.
  task automatic push_beat(input int rel, input int o, input logic d);
    beat_t b;
    logic [1:0] s;
    s       = 2'(3 - o);
    b.rel   = 16'(rel);
    b.grant = 4'(1 << o);
    b.sel   = s;
    b.data  = d;
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    din = 4'b0000;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    din = 4'b1111;
    out_ready = 1'b1;
    tick();
    tick();
    #2;
    n_checks++;
    if ({grant, sel} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset grant/sel: actual grant=%b sel=%0d, required 0000/0", grant, sel);
    end
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset busy/valid: actual busy=%b valid=%b, required 0/0", busy, out_valid);
    end
    rst = 1'b0;
    req = 4'b0000;
    tick();
    #2;
    n_checks++;
    if ({grant, busy, out_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset idle: actual grant=%b busy=%b valid=%b, required 0000/0/0", grant, busy, out_valid);
    end
    $display("reset checked");
    obs_q.delete();
  endtask

  task automatic test_single();
    beat_t e, o;
    do_reset();
    base = cyc;
    for (int r = 0; r <= 10; r++) begin
      req = (r < 10) ? 4'b0100 : 4'b0000;
      din = 4'b0100;
      out_ready = 1'b1;
      if ((r >= 1 && r <= 4) || (r >= 6 && r <= 9)) push_beat(r, 2, 1'b1);
      #2;
      if (r == 1) begin
        n_checks++;
        if (grant !== 4'b0100 || sel !== 2'd1 || out_data !== 1'b1) begin
          n_fail++;
          $display("FAIL single first: actual grant=%b sel=%0d data=%b, required 0100/1/1", grant, sel, out_data);
        end
      end
      if (r == 5) begin
        n_checks++;
        if (busy !== 1'b0 || grant !== 4'b0000) begin
          n_fail++;
          $display("FAIL single bubble: actual busy=%b grant=%b, required 0/0000", busy, grant);
        end
      end
      tick();
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL single beat count: actual %0d unmatched, required %0d unmatched", obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL single beat: actual rel=%0d grant=%b sel=%0d data=%b, required rel=%0d grant=%b sel=%0d data=%b",
                   o.rel, o.grant, o.sel, o.data, e.rel, e.grant, e.sel, e.data);
        end else begin
          $display("single beat rel=%0d grant=%b sel=%0d data=%b", o.rel, o.grant, o.sel, o.data);
        end
      end
    end
  endtask

  task automatic test_fairness();
    beat_t e, o;
    do_reset();
    base = cyc;
    din = 4'b0110;
    for (int r = 0; r <= 25; r++) begin
      req = (r <= 24) ? 4'b1111 : 4'b0000;
      out_ready = 1'b1;
      if (r >= 1 && ((r - 1) % 5) < 4) push_beat(r, ((r - 1) / 5) % 4, din[((r - 1) / 5) % 4]);
      #2;
      if (r == 5 || r == 10 || r == 15 || r == 20) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL fairness bubble rel=%0d: actual busy=%b, required 0", r, busy);
        end
      end
      tick();
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL fairness beat count: actual %0d unmatched, required %0d unmatched", obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL fairness beat: actual rel=%0d grant=%b sel=%0d data=%b, required rel=%0d grant=%b sel=%0d data=%b",
                   o.rel, o.grant, o.sel, o.data, e.rel, e.grant, e.sel, e.data);
        end else begin
          $display("fairness beat rel=%0d grant=%b sel=%0d data=%b", o.rel, o.grant, o.sel, o.data);
        end
      end
    end
  endtask

  task automatic test_early_release();
    beat_t e, o;
    do_reset();
    base = cyc;
    din = 4'b0010;
    for (int r = 0; r <= 9; r++) begin
      req = (r < 3) ? 4'b1110 : ((r < 9) ? 4'b1100 : 4'b0000);
      out_ready = 1'b1;
      if (r == 1 || r == 2) push_beat(r, 1, 1'b1);
      if (r >= 5 && r <= 8) push_beat(r, 2, 1'b0);
      #2;
      if (r == 3) begin
        n_checks++;
        if (out_valid !== 1'b0 || grant !== 4'b0010) begin
          n_fail++;
          $display("FAIL early drop: actual valid=%b grant=%b, required 0/0010", out_valid, grant);
        end
      end
      if (r == 4) begin
        n_checks++;
        if (busy !== 1'b0 || grant !== 4'b0000) begin
          n_fail++;
          $display("FAIL early release: actual busy=%b grant=%b, required 0/0000", busy, grant);
        end
      end
      if (r == 5) begin
        n_checks++;
        if (grant !== 4'b0100 || sel !== 2'd1) begin
          n_fail++;
          $display("FAIL early next owner: actual grant=%b sel=%0d, required 0100/1", grant, sel);
        end
      end
      tick();
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL early beat count: actual %0d unmatched, required %0d unmatched", obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL early beat: actual rel=%0d grant=%b sel=%0d data=%b, required rel=%0d grant=%b sel=%0d data=%b",
                   o.rel, o.grant, o.sel, o.data, e.rel, e.grant, e.sel, e.data);
        end else begin
          $display("early beat rel=%0d grant=%b sel=%0d data=%b", o.rel, o.grant, o.sel, o.data);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    beat_t e, o;
    do_reset();
    base = cyc;
    for (int r = 0; r <= 15; r++) begin
      req = (r < 15) ? 4'b1000 : 4'b0000;
      din = 4'($urandom_range(0, 15));
      out_ready = (r >= 11);
      if (r >= 11 && r <= 14) push_beat(r, 3, din[3]);
      #2;
      if (r >= 1 && r <= 10) begin
        n_checks++;
        if ({out_valid, grant} !== 5'b11000) begin
          n_fail++;
          $display("FAIL stall rel=%0d: actual valid=%b grant=%b, required 1/1000", r, out_valid, grant);
        end
      end
      if (r == 15) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL stall release: actual busy=%b, required 0", busy);
        end
      end
      tick();
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL stall beat count: actual %0d unmatched, required %0d unmatched", obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL stall beat: actual rel=%0d grant=%b sel=%0d data=%b, required rel=%0d grant=%b sel=%0d data=%b",
                   o.rel, o.grant, o.sel, o.data, e.rel, e.grant, e.sel, e.data);
        end else begin
          $display("stall beat rel=%0d grant=%b sel=%0d data=%b", o.rel, o.grant, o.sel, o.data);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    beat_t e, o;
    do_reset();
    base = cyc;
    din = 4'b0001;
    for (int r = 0; r <= 9; r++) begin
      req = (r < 9) ? 4'b1111 : 4'b0000;
      rst = (r == 3);
      out_ready = 1'b1;
      if (r == 1 || r == 2 || (r >= 5 && r <= 8)) push_beat(r, 0, 1'b1);
      #2;
      if (r == 3) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL midrst valid: actual valid=%b, required 0", out_valid);
        end
      end
      if (r == 4) begin
        n_checks++;
        if ({grant, out_valid, busy} !== 6'b0) begin
          n_fail++;
          $display("FAIL midrst state: actual grant=%b valid=%b busy=%b, required 0000/0/0", grant, out_valid, busy);
        end
      end
      if (r == 5) begin
        n_checks++;
        if (grant !== 4'b0001 || sel !== 2'd3) begin
          n_fail++;
          $display("FAIL midrst first grant: actual grant=%b sel=%0d, required 0001/3", grant, sel);
        end
      end
      tick();
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL midrst beat count: actual %0d unmatched, required %0d unmatched", obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL midrst beat: actual rel=%0d grant=%b sel=%0d data=%b, required rel=%0d grant=%b sel=%0d data=%b",
                   o.rel, o.grant, o.sel, o.data, e.rel, e.grant, e.sel, e.data);
        end else begin
          $display("midrst beat rel=%0d grant=%b sel=%0d data=%b", o.rel, o.grant, o.sel, o.data);
        end
      end
    end
  endtask

  task automatic test_select_map();
    logic [3:0] oh;
    logic [1:0] want_sel;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      oh = 4'(1 << i);
      want_sel = 2'(3 - i);
      for (int r = 0; r <= 3; r++) begin
        req = (r < 2) ? oh : 4'b0000;
        din = (r < 2) ? oh : ~oh;
        out_ready = 1'b0;
        #2;
        if (r == 1) begin
          n_checks++;
          if (grant !== oh || sel !== want_sel || out_data !== 1'b1) begin
            n_fail++;
            $display("FAIL selmap %0d: actual grant=%b sel=%0d data=%b, required %b/%0d/1", i, grant, sel, out_data, oh, want_sel);
          end else begin
            $display("selmap requester %0d sel=%0d data=%b", i, sel, out_data);
          end
        end
        if (r == 2) begin
          n_checks++;
          if (out_data !== 1'b0) begin
            n_fail++;
            $display("FAIL selmap %0d low: actual data=%b, required 0", i, out_data);
          end
        end
        tick();
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL selmap stray beats: actual %0d, required 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    din = 4'b0000;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_early_release();
    test_backpressure();
    test_reset_mid_burst();
    test_select_map();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
